// File: rtl/cursor_scroll_unit.sv
// Terminal cursor / scroll-region controller between the escape parser and the text-RAM editor.
// Optional deferred wrap is enabled with `define CURSOR_AUTOWRAP_EN.
module cursor_scroll_unit #(
  parameter int unsigned COLUMNS = 80,
  parameter int unsigned LINES   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_type,
  input  logic [7:0] cmd_pn1,
  input  logic [7:0] cmd_pn2,
  input  logic [7:0] margin_top,
  input  logic [7:0] margin_bottom,
  output logic [7:0] cursor_row,
  output logic [7:0] cursor_col,
  output logic       wrap_pending,
  output logic       print_valid,
  output logic [7:0] print_row,
  output logic [7:0] print_col,
  output logic       scroll_ready,
  output logic [7:0] scroll_top,
  output logic [7:0] scroll_bottom,
  output logic [7:0] scroll_step,
  output logic       scroll_dir,
  input  logic       scroll_ack
);

`ifdef CURSOR_AUTOWRAP_EN
  localparam bit AutoWrap = 1'b1;
`else
  localparam bit AutoWrap = 1'b0;
`endif

  localparam logic [7:0] MaxRow = 8'(LINES - 1);
  localparam logic [7:0] MaxCol = 8'(COLUMNS - 1);

  localparam logic [2:0] CmdPrint = 3'd1;
  localparam logic [2:0] CmdLf    = 3'd2;
  localparam logic [2:0] CmdCr    = 3'd3;
  localparam logic [2:0] CmdRi    = 3'd4;
  localparam logic [2:0] CmdBs    = 3'd5;
  localparam logic [2:0] CmdCup   = 3'd6;
  localparam logic [2:0] CmdNel   = 3'd7;

  typedef enum logic [1:0] {StIdle, StScrollWait, StPrintOut} state_e;

  state_e     state_q, state_d;
  logic [7:0] row_q, row_d, col_q, col_d;
  logic       wrap_q, wrap_d;
  logic       pend_q, pend_d;
  logic       sready_q, sready_d;
  logic [7:0] stop_q, stop_d, sbot_q, sbot_d, sstep_q, sstep_d;
  logic       sdir_q, sdir_d;

  logic       accept;
  logic [7:0] top_eff, bot_eff;
  logic       lf_scroll;
  logic [7:0] lf_row;
  logic [7:0] cup_row, cup_col;

  always_comb begin
    accept = cmd_valid && (state_q == StIdle);
    // Degenerate or off-screen regions fall back to the full screen.
    if ((margin_top >= margin_bottom) || (margin_bottom > MaxRow)) begin
      top_eff = 8'd0;
      bot_eff = MaxRow;
    end else begin
      top_eff = margin_top;
      bot_eff = margin_bottom;
    end
    lf_scroll = (row_q == bot_eff);
    lf_row    = (row_q < MaxRow) ? row_q + 8'd1 : row_q;
    cup_row   = (cmd_pn1 == 8'd0) ? 8'd0 : cmd_pn1 - 8'd1;
    cup_col   = (cmd_pn2 == 8'd0) ? 8'd0 : cmd_pn2 - 8'd1;
    if (cup_row > MaxRow) cup_row = MaxRow;
    if (cup_col > MaxCol) cup_col = MaxCol;
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    wrap_d   = wrap_q;
    pend_d   = pend_q;
    sready_d = sready_q;
    stop_d   = stop_q;
    sbot_d   = sbot_q;
    sstep_d  = sstep_q;
    sdir_d   = sdir_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_type)
            CmdPrint: begin
              state_d = StPrintOut;
              if (wrap_q) begin
                col_d  = 8'd0;
                wrap_d = 1'b0;
                if (lf_scroll) begin
                  pend_d  = 1'b1;
                  state_d = StScrollWait;
                end else begin
                  row_d = lf_row;
                end
              end
            end
            CmdLf, CmdNel: begin
              wrap_d = 1'b0;
              if (cmd_type == CmdNel) col_d = 8'd0;
              if (lf_scroll) state_d = StScrollWait;
              else row_d = lf_row;
            end
            CmdCr: begin
              col_d  = 8'd0;
              wrap_d = 1'b0;
            end
            CmdRi: begin
              wrap_d = 1'b0;
              if (row_q == top_eff) state_d = StScrollWait;
              else if (row_q != 8'd0) row_d = row_q - 8'd1;
            end
            CmdBs: begin
              wrap_d = 1'b0;
              if (col_q != 8'd0) col_d = col_q - 8'd1;
            end
            CmdCup: begin
              row_d  = cup_row;
              col_d  = cup_col;
              wrap_d = 1'b0;
            end
            default: ;
          endcase
          if (state_d == StScrollWait) begin
            sready_d = 1'b1;
            stop_d   = top_eff;
            sbot_d   = bot_eff;
            sstep_d  = 8'd1;
            sdir_d   = (cmd_type == CmdRi);
          end
        end
      end
      StScrollWait: begin
        if (scroll_ack) begin
          sready_d = 1'b0;
          pend_d   = 1'b0;
          state_d  = pend_q ? StPrintOut : StIdle;
        end
      end
      StPrintOut: begin
        state_d = StIdle;
        if (col_q < MaxCol) col_d = col_q + 8'd1;
        else wrap_d = AutoWrap;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      row_q    <= 8'd0;
      col_q    <= 8'd0;
      wrap_q   <= 1'b0;
      pend_q   <= 1'b0;
      sready_q <= 1'b0;
      stop_q   <= 8'd0;
      sbot_q   <= 8'd0;
      sstep_q  <= 8'd0;
      sdir_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wrap_q   <= wrap_d;
      pend_q   <= pend_d;
      sready_q <= sready_d;
      stop_q   <= stop_d;
      sbot_q   <= sbot_d;
      sstep_q  <= sstep_d;
      sdir_q   <= sdir_d;
    end
  end

  always_comb begin
    cmd_ready     = (state_q == StIdle);
    cursor_row    = row_q;
    cursor_col    = col_q;
    wrap_pending  = wrap_q;
    print_valid   = (state_q == StPrintOut);
    print_row     = print_valid ? row_q : 8'd0;
    print_col     = print_valid ? col_q : 8'd0;
    scroll_ready  = sready_q;
    scroll_top    = stop_q;
    scroll_bottom = sbot_q;
    scroll_step   = sstep_q;
    scroll_dir    = sdir_q;
  end

endmodule
